// File: rtl/adder_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adder_seq_pkg
//  Description : Shared types and helpers for the sliced sequential adder:
//                FSM state encoding, slice count and index width functions.
//  Revision    : 1.0 - initial release
// ============================================================================
package adder_seq_pkg;

  // Controller states, explicitly 2 bits wide
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of clocks (slices) needed for one operation
  function automatic int nslice(input int width, input int slice);
    return width / slice;
  endfunction

  // Slice index width; a single-slice configuration still gets a 1-bit index
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adder_slice.sv
`default_nettype none
// ============================================================================
//  Module      : adder_slice
//  Description : Combinational SLICE-bit ripple-carry adder. Besides the
//                carry-out it exposes the carry into the top bit so the
//                caller can derive signed overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             ci,
  output logic [SLICE-1:0] s,
  output logic             co,
  output logic             c_msb
);

  // Ripple the carry bit by bit; carry chain kept local to avoid a split loop
  always_comb begin
    logic [SLICE:0] w_c;
    w_c    = '0;
    s      = '0;
    w_c[0] = ci;
    for (int i = 0; i < SLICE; i++) begin
      s[i]     = a[i] ^ b[i] ^ w_c[i];
      w_c[i+1] = (a[i] & b[i]) | (a[i] & w_c[i]) | (b[i] & w_c[i]);
    end
    co    = w_c[SLICE];
    c_msb = w_c[SLICE-1];
  end

endmodule
`default_nettype wire

// File: rtl/adder_seq_sliced.sv
`default_nettype none
// ============================================================================
//  Module      : adder_seq_sliced
//  Description : Multi-cycle WIDTH-bit adder/subtractor. One SLICE-bit ripple
//                slice is reused for WIDTH/SLICE clocks with a registered
//                carry between slices. valid/ready on input and output.
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_seq_sliced
  import adder_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int c_nslice = nslice(WIDTH, SLICE);
  localparam int c_idx_w  = idx_width(c_nslice);
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(c_nslice - 1);

  // A width that is not a whole number of slices cannot be processed
  if ((WIDTH % SLICE) != 0) begin : g_param_check
    $error("adder_seq_sliced: WIDTH must be a multiple of SLICE");
  end

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;      // b already inverted for subtract
  logic               carry_q, carry_d;
  logic [c_idx_w-1:0] idx_q, idx_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic [WIDTH-1:0]   w_a_shift, w_b_shift;
  logic [SLICE-1:0]   w_slice_s;
  logic               w_slice_co, w_slice_c_msb;

  // Bring the active slice down to the bottom bits for the shared adder
  assign w_a_shift = a_q >> (SLICE * int'(idx_q));
  assign w_b_shift = b_q >> (SLICE * int'(idx_q));

  adder_slice #(.SLICE(SLICE)) u_slice (
    .a     (w_a_shift[SLICE-1:0]),
    .b     (w_b_shift[SLICE-1:0]),
    .ci    (carry_q),
    .s     (w_slice_s),
    .co    (w_slice_co),
    .c_msb (w_slice_c_msb)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)            state_d = RUN;
      RUN:     if (idx_q == c_last_idx) state_d = DONE;
      DONE:    if (out_ready)           state_d = IDLE;
      default:                          state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Datapath next values: capture operands on accept, one slice per RUN clock
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (in_valid && in_ready) begin
      a_d     = a;
      b_d     = sub ? ~b : b;
      carry_d = sub ? 1'b1 : cin;
      idx_d   = '0;
    end else if (state_q == RUN) begin
      for (int i = 0; i < c_nslice; i++) begin
        if (idx_q == c_idx_w'(i)) sum_d[i*SLICE +: SLICE] = w_slice_s;
      end
      carry_d = w_slice_co;
      idx_d   = idx_q + c_idx_w'(1);
      if (idx_q == c_last_idx) begin
        cout_d = w_slice_co;
        ovf_d  = w_slice_co ^ w_slice_c_msb;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
`default_nettype wire
